des_round_seq: RTL

DES_ROUND_SEQ -- requirements
Module: des_round_seq

---
 rtl/des_round_seq.sv | 99 +++++++++
 1 files changed

// File: rtl/des_round_seq.sv
// Sequencer for an external iterative DES round core: latches one request, steps
// the core through rounds 0..15 and holds the registered result until it is taken.
module des_round_seq #(
  parameter int NROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] data_in,
  input  logic [55:0] key_in,
  input  logic        decrypt_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy,
  output logic [63:0] core_desIn,
  output logic [55:0] core_key,
  output logic        core_decrypt,
  output logic [3:0]  core_roundSel,
  input  logic [63:0] core_desOut
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_DONE     = 2'd2;
  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS - 1);

  logic [1:0]  r_state;
  logic [3:0]  r_round;
  logic [63:0] r_blk;
  logic [55:0] r_key;
  logic        r_decrypt;
  logic        r_out_valid;
  logic [63:0] r_data_out;
  logic        w_accept;
  logic        w_last_round;

  assign in_ready     = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign w_accept     = in_valid && in_ready;
  assign w_last_round = (r_round == LAST_ROUND);

  // The core only ever sees the latched copy, so port activity during RUN is invisible to it.
  assign core_desIn    = r_blk;
  assign core_key      = r_key;
  assign core_decrypt  = r_decrypt;
  assign core_roundSel = r_round;

  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_round     <= 4'd0;
      r_blk       <= 64'd0;
      r_key       <= 56'd0;
      r_decrypt   <= 1'b0;
      r_out_valid <= 1'b0;
      r_data_out  <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_blk     <= data_in;
            r_key     <= key_in;
            r_decrypt <= decrypt_in;
            r_round   <= 4'd0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          // Final round: the core output is combinational, so capture it in the same cycle.
          if (w_last_round) begin
            r_data_out  <= core_desOut;
            r_out_valid <= 1'b1;
            r_round     <= 4'd0;
            r_state     <= S_DONE;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_round     <= 4'd0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
